// File: rtl/pattern_seeder.sv
// Row-by-row arena seeder: clear, fill, random or sparse random over a row window.
// Define SEEDER_SPARSE_EN to build the sparse AND-of-two-bits pattern for mode 11.
module pattern_seeder #(
   parameter int                    ARENA_WIDTH  = 10,
   parameter int                    ARENA_HEIGHT = 10,
   parameter int                    LFSR_WIDTH   = 32,
   parameter logic [LFSR_WIDTH-1:0] LFSR_TAPS    = 32'h8020_0003
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic                   abort,
   input  logic [1:0]             mode,
   input  logic                   reseed,
   input  logic [LFSR_WIDTH-1:0]  seed,
   input  logic [9:0]             row_first,
   input  logic [9:0]             row_last,
   output logic                   ready,
   output logic                   done,
   output logic [9:0]             arena_row_select,
   output logic [ARENA_WIDTH-1:0] arena_columns_new,
   output logic                   arena_columns_write
);

   localparam int              CW       = $clog2(ARENA_WIDTH);
   localparam int              LW       = LFSR_WIDTH;
   localparam int              W        = ARENA_WIDTH;
   localparam logic [9:0]      ROW_MAX  = 10'(ARENA_HEIGHT - 1);
   localparam logic [CW-1:0]   COL_LAST = CW'(ARENA_WIDTH - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_GEN,
      S_WRITE,
      S_DONE
   } state_t;

   state_t          state_q;
   logic [1:0]      mode_q;
   logic            reseed_q;
   logic [9:0]      first_q;
   logic [9:0]      last_q;
   logic [9:0]      cur_q;
   logic [CW-1:0]   col_q;
   logic [LW-1:0]   lfsr_q;
   logic [W-1:0]    rowbuf_q;
   logic            ready_q;
   logic            done_q;
   logic            wr_q;
   logic [9:0]      rsel_q;
   logic [W-1:0]    cols_q;

   logic            fb;
   logic            gen_bit;
   logic [LW-1:0]   lfsr_d;
   logic [W-1:0]    rowbuf_d;
   logic [9:0]      last_d;
   logic [LW-1:0]   seed_safe;
   logic [W-1:0]    fill_row;

   assign fb        = ^(lfsr_q & LFSR_TAPS);
   assign lfsr_d    = {lfsr_q[LW-2:0], fb};
   assign rowbuf_d  = {rowbuf_q[W-2:0], gen_bit};
   assign last_d    = (row_last > ROW_MAX) ? ROW_MAX : row_last;
   assign seed_safe = (seed == '0) ? LW'(1) : seed;
   assign fill_row  = {W{mode_q[0]}};

`ifdef SEEDER_SPARSE_EN
   assign gen_bit = (mode_q == 2'b11) ? (lfsr_q[LW-1] & lfsr_q[LW-2])
                                      : lfsr_q[LW-1];
`else
   assign gen_bit = lfsr_q[LW-1];
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= S_IDLE;
         mode_q   <= 2'b00;
         reseed_q <= 1'b0;
         first_q  <= '0;
         last_q   <= '0;
         cur_q    <= '0;
         col_q    <= '0;
         lfsr_q   <= LW'(1);
         rowbuf_q <= '0;
         ready_q  <= 1'b1;
         done_q   <= 1'b0;
         wr_q     <= 1'b0;
         rsel_q   <= '0;
         cols_q   <= '0;
      end else begin
         done_q <= 1'b0;
         wr_q   <= 1'b0;
         unique case (state_q)
            S_IDLE, S_DONE: begin
               if (start) begin
                  mode_q   <= mode;
                  reseed_q <= reseed;
                  first_q  <= row_first;
                  last_q   <= last_d;
                  ready_q  <= 1'b0;
                  state_q  <= S_LOAD;
               end else begin
                  ready_q  <= 1'b1;
                  state_q  <= S_IDLE;
               end
            end
            S_LOAD: begin
               if (abort) begin
                  ready_q <= 1'b1;
                  state_q <= S_IDLE;
               end else begin
                  if (reseed_q) lfsr_q <= seed_safe;
                  cur_q <= first_q;
                  col_q <= '0;
                  if (first_q > last_q) begin
                     done_q  <= 1'b1;
                     ready_q <= 1'b1;
                     state_q <= S_DONE;
                  end else if (mode_q[1]) begin
                     state_q <= S_GEN;
                  end else begin
                     wr_q    <= 1'b1;
                     rsel_q  <= first_q;
                     cols_q  <= fill_row;
                     state_q <= S_WRITE;
                  end
               end
            end
            S_GEN: begin
               if (abort) begin
                  ready_q <= 1'b1;
                  state_q <= S_IDLE;
               end else begin
                  lfsr_q   <= lfsr_d;
                  rowbuf_q <= rowbuf_d;
                  col_q    <= col_q + 1'b1;
                  // Outputs are registered, so load them on the last GEN beat.
                  if (col_q == COL_LAST) begin
                     wr_q    <= 1'b1;
                     rsel_q  <= cur_q;
                     cols_q  <= rowbuf_d;
                     state_q <= S_WRITE;
                  end
               end
            end
            S_WRITE: begin
               if (abort) begin
                  ready_q <= 1'b1;
                  state_q <= S_IDLE;
               end else if (cur_q == last_q) begin
                  done_q  <= 1'b1;
                  ready_q <= 1'b1;
                  state_q <= S_DONE;
               end else begin
                  cur_q <= cur_q + 10'd1;
                  col_q <= '0;
                  if (mode_q[1]) begin
                     state_q <= S_GEN;
                  end else begin
                     wr_q    <= 1'b1;
                     rsel_q  <= cur_q + 10'd1;
                     cols_q  <= fill_row;
                     state_q <= S_WRITE;
                  end
               end
            end
            default: begin
               ready_q <= 1'b1;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign ready               = ready_q;
   assign done                = done_q;
   assign arena_row_select    = rsel_q;
   assign arena_columns_new   = cols_q;
   assign arena_columns_write = wr_q;

endmodule

// File: tb/tb_pattern_seeder.sv
// Scoreboard bench for pattern_seeder (W=4, H=3, 8-bit LFSR, taps 8'hB8).
// Expected writes/done pulses are queued at launch and popped by a monitor.
module tb_pattern_seeder;

   localparam int         W    = 4;
   localparam int         H    = 3;
   localparam int         LW   = 8;
   localparam logic [7:0] TAPS = 8'hB8;
`ifdef SEEDER_SPARSE_EN
   localparam bit SPARSE = 1'b1;
`else
   localparam bit SPARSE = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic       abort = 1'b0;
   logic       reseed = 1'b0;
   logic [1:0] mode = 2'b00;
   logic [7:0] seed = 8'h00;
   logic [9:0] row_first = '0;
   logic [9:0] row_last = '0;
   logic       ready;
   logic       done;
   logic       wr;
   logic [9:0] rsel;
   logic [3:0] cols;

   pattern_seeder #(
      .ARENA_WIDTH (W),
      .ARENA_HEIGHT(H),
      .LFSR_WIDTH  (LW),
      .LFSR_TAPS   (TAPS)
   ) dut (
      .clk                (clk),
      .reset              (reset),
      .start              (start),
      .abort              (abort),
      .mode               (mode),
      .reseed             (reseed),
      .seed               (seed),
      .row_first          (row_first),
      .row_last           (row_last),
      .ready              (ready),
      .done               (done),
      .arena_row_select   (rsel),
      .arena_columns_new  (cols),
      .arena_columns_write(wr)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int         cyc;
      logic [9:0] row;
      logic [3:0] data;
   } wr_t;

   wr_t        exp_wr[$];
   int         exp_done[$];
   int         total = 0;
   int         bad = 0;
   logic [7:0] mlfsr = 8'h01;

   function automatic void chk(string n, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", n, act, exp, cyc);
      end
   endfunction

   // Reference LFSR: shift left, new LSB is the parity of the tapped bits.
   function automatic void model_step();
      int ones;
      ones  = $countones(mlfsr & TAPS);
      mlfsr = {mlfsr[6:0], ones[0]};
   endfunction

   function automatic logic [3:0] model_row(input logic [1:0] m);
      logic [3:0] r;
      logic       b;
      r = '0;
      for (int i = 0; i < W; i++) begin
         b = mlfsr[7];
         if (SPARSE && m == 2'b11) b = mlfsr[7] & mlfsr[6];
         r = {r[2:0], b};
         model_step();
      end
      return r;
   endfunction

   task automatic wait_until(input int t);
      int g;
      g = 0;
      while (cyc < t && g < 5000) begin
         @(negedge clk);
         g++;
      end
      if (cyc < t) begin
         total++;
         bad++;
         $display("FAIL wait_timeout: at cycle %0d, expected to reach %0d", cyc, t);
      end
   endtask

   // keep < 0: whole run expected; keep >= 0: only that many rows, no done.
   task automatic launch(input logic [1:0] m, input logic rs,
                         input logic [7:0] sd, input logic [9:0] f,
                         input logic [9:0] l, input int keep,
                         output int c, output int d);
      int  last;
      int  n;
      wr_t e;
      mode      = m;
      reseed    = rs;
      seed      = sd;
      row_first = f;
      row_last  = l;
      start     = 1'b1;
      c         = cyc;
      last      = (int'(l) > H - 1) ? H - 1 : int'(l);
      n         = (int'(f) > last) ? 0 : last - int'(f) + 1;
      if (rs) mlfsr = (sd == 8'h00) ? 8'h01 : sd;
      for (int k = 0; k < n && (keep < 0 || k < keep); k++) begin
         e.row = 10'(int'(f) + k);
         if (m[1]) begin
            e.cyc  = c + 2 + W + k * (W + 1);
            e.data = model_row(m);
         end else begin
            e.cyc  = c + 2 + k;
            e.data = m[0] ? 4'hF : 4'h0;
         end
         exp_wr.push_back(e);
      end
      d = m[1] ? c + 2 + n * (W + 1) : c + 2 + n;
      if (keep < 0) exp_done.push_back(d);
      @(negedge clk);
      start = 1'b0;
      chk("ready_low_in_load", {31'd0, ready}, 32'd0);
   endtask

   initial begin
      int         c;
      int         d;
      wr_t        me;
      logic [1:0] rm;
      logic       rrs;
      logic [7:0] rsd;

      fork
         forever begin
            @(negedge clk);
            if (!reset) begin
               if (wr) begin
                  if (exp_wr.size() == 0) begin
                     total++;
                     bad++;
                     $display("FAIL unexpected_write: row %0d data %b at cycle %0d, expected none",
                              rsel, cols, cyc);
                  end else begin
                     me = exp_wr.pop_front();
                     chk("write_cycle", cyc, me.cyc);
                     chk("write_row", {22'd0, rsel}, {22'd0, me.row});
                     chk("write_data", {28'd0, cols}, {28'd0, me.data});
                  end
               end
               if (done) begin
                  if (exp_done.size() == 0) begin
                     total++;
                     bad++;
                     $display("FAIL unexpected_done: pulse at cycle %0d, expected none", cyc);
                  end else begin
                     chk("done_cycle", cyc, exp_done.pop_front());
                     chk("ready_in_done", {31'd0, ready}, 32'd1);
                  end
               end
            end
         end
      join_none

      repeat (2) @(negedge clk);
      chk("rst_ready", {31'd0, ready}, 32'd1);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_write", {31'd0, wr}, 32'd0);
      chk("rst_row", {22'd0, rsel}, 32'd0);
      chk("rst_cols", {28'd0, cols}, 32'd0);
      reset = 1'b0;
      @(negedge clk);

      launch(2'b01, 1'b0, 8'h00, 10'd0, 10'd2, -1, c, d);
      wait_until(d + 1);
      launch(2'b10, 1'b1, 8'h80, 10'd0, 10'd0, -1, c, d);
      wait_until(d + 1);
      launch(2'b10, 1'b0, 8'h80, 10'd0, 10'd0, -1, c, d);
      wait_until(d + 1);
      launch(2'b10, 1'b1, 8'h00, 10'd0, 10'd2, -1, c, d);
      wait_until(d + 1);
      launch(2'b01, 1'b0, 8'h00, 10'd2, 10'd7, -1, c, d);
      wait_until(d + 1);
      launch(2'b00, 1'b0, 8'h00, 10'd2, 10'd1, -1, c, d);
      wait_until(d + 1);
      launch(2'b11, 1'b0, 8'h00, 10'd5, 10'd9, -1, c, d);
      wait_until(d + 1);

      launch(2'b00, 1'b0, 8'h00, 10'd0, 10'd1, -1, c, d);
      wait_until(d);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      wait_until(d + 2);

      launch(2'b11, 1'b1, 8'h5A, 10'd1, 10'd2, -1, c, d);
      wait_until(d);
      launch(2'b01, 1'b0, 8'h00, 10'd0, 10'd0, -1, c, d);
      wait_until(d + 1);

      launch(2'b10, 1'b1, 8'hC3, 10'd0, 10'd2, 1, c, d);
      wait_until(c + 8);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      model_step();
      chk("ready_after_abort", {31'd0, ready}, 32'd1);
      wait_until(c + 25);
      launch(2'b10, 1'b0, 8'h00, 10'd0, 10'd1, -1, c, d);
      wait_until(d + 1);

      launch(2'b01, 1'b0, 8'h00, 10'd0, 10'd2, 2, c, d);
      wait_until(c + 3);
      #2 reset = 1'b1;
      #1;
      chk("midrun_rst_write", {31'd0, wr}, 32'd0);
      chk("midrun_rst_ready", {31'd0, ready}, 32'd1);
      chk("midrun_rst_done", {31'd0, done}, 32'd0);
      chk("midrun_rst_row", {22'd0, rsel}, 32'd0);
      chk("midrun_rst_cols", {28'd0, cols}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      mlfsr = 8'h01;
      @(negedge clk);
      launch(2'b10, 1'b0, 8'h00, 10'd0, 10'd0, -1, c, d);
      wait_until(d + 1);

      for (int i = 0; i < 16; i++) begin
         rm  = 2'($urandom_range(0, 3));
         rrs = ($urandom_range(0, 3) != 0);
         rsd = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom);
         launch(rm, rrs, rsd, 10'($urandom_range(0, 3)),
                10'($urandom_range(0, 6)), -1, c, d);
         if (d > c + 3 && $urandom_range(0, 1) == 1) begin
            wait_until(c + 3);
            mode  = ~rm;
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
         end
         if ($urandom_range(0, 1) == 1) wait_until(d);
         else wait_until(d + 1 + $urandom_range(0, 2));
      end
      wait_until(cyc + 30);

      chk("writes_left", exp_wr.size(), 32'd0);
      chk("dones_left", exp_done.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pattern_seeder.md
# pattern_seeder

Parametrised successor to the arena seeder. It fills a selectable row range of the Life arena with one of four patterns: clear, fill, pseudo-random, or sparse pseudo-random. The block sits between the control FSM and the arena row-write port, and writes one full row per write strobe. It adds the following:
- a configurable LFSR with lock-up protection;
- a row window;
- an abort input;
- a `done` pulse;
- an LFSR that holds between runs, so a sequence can continue without reseeding.

## Interface
- `ARENA_WIDTH`, 10: columns per row (≥2).
- `ARENA_HEIGHT`, 10: rows in the arena (≤1024).
- `LFSR_WIDTH`, 32: LFSR length (≥4).
- `LFSR_TAPS`, 32'h8020_0003: feedback mask, `LFSR_WIDTH` bits; feedback = XOR-reduce(`lfsr & LFSR_TAPS`).
- `clk`, input, 1: clock.
- `reset`, input, 1: asynchronous, active-high.
- `start`, input, 1: request a run; accepted only while `ready`=1.
- `abort`, input, 1: cancel the current run.
- `mode`, input, 2: 00 clear, 01 fill, 10 random, 11 sparse. Sampled at start.
- `reseed`, input, 1: 1 loads `seed`; 0 continues from the current LFSR state. Sampled at start.
- `seed`, input, `LFSR_WIDTH`: LFSR seed.
- `row_first`, input, 10: first row of the window. Sampled at start.
- `row_last`, input, 10: last row of the window. Sampled at start.
- `ready`, output, 1: idle and able to accept `start`.
- `done`, output, 1: one-cycle pulse when a run completes normally.
- `arena_row_select`, output, 10: row currently being written.
- `arena_columns_new`, output, `ARENA_WIDTH`: row data.
- `arena_columns_write`, output, 1: row write strobe.

## Operation
- **IDLE:** `ready`=1. When `start`=1:
  - latch `mode`, `row_first`, and `min(row_last, ARENA_HEIGHT-1)`;
  - go to LOAD.
- **LOAD** (1 cycle):
  - if the latched `reseed`=1, set `lfsr` = `seed`, or 1 when `seed`=0 (lock-up protection);
  - set `cur_row` = `row_first`;
  - clear `col`.
  - Next state:
    - if `row_first` > clamped `row_last` (this includes `row_first` ≥ `ARENA_HEIGHT`), go to DONE with no writes;
    - otherwise go to GEN for modes 1x, or to WRITE for modes 0x.
- **GEN** (`ARENA_WIDTH` cycles per row):
  - each cycle sets `rowbuf` = {`rowbuf[W-2:0]`, bit}, so the first generated bit ends up in column `W-1`;
  - random mode: bit = `lfsr[MSB]`;
  - sparse mode: bit = `lfsr[MSB] & lfsr[MSB-1]` (about 25 % density);
  - the LFSR advances one step per GEN cycle: `lfsr` ← {`lfsr[LW-2:0]`, feedback};
  - the LFSR holds in every other state;
  - when `col` = `W-1`, go to WRITE.
- **WRITE** (1 cycle):
  - `arena_columns_write`=1, `arena_row_select`=`cur_row`;
  - `arena_columns_new` = `rowbuf`, or all-0 / all-1 for clear / fill.
  - If `cur_row` = `row_last`, go to DONE. Otherwise increment `cur_row`, clear `col`, and go to GEN (random modes) or stay in WRITE (fill modes).
- **DONE** (1 cycle): `done`=1, `ready`=1, next state IDLE. A `start` in this cycle is accepted exactly as in IDLE.
- **abort**=1 in LOAD, GEN or WRITE:
  - next state is IDLE, with no `done` pulse;
  - a write already asserted in the abort cycle still completes;
  - the LFSR keeps its current value.
- `abort` in IDLE or DONE has no effect.
- `start` while busy is ignored.
- **Reset values:** state IDLE, `ready`=1, `done`=0, `arena_columns_write`=0, `arena_row_select`=0, `arena_columns_new`=0, `lfsr`=1, `rowbuf`=0. Reset mid-run discards the run; the write strobe drops immediately (asynchronously).

## Timing
- `start` is sampled at cycle t. LOAD is at t+1, and `ready` falls at t+1.
- Random modes:
  - row k (from 0) is written at t+2+W+k·(W+1);
  - the last write is at t+1+N·(W+1), where N = number of rows;
  - `done` is at t+2+N·(W+1).
- Clear/fill: writes occur on consecutive cycles t+2…t+1+N, and `done` is at t+2+N.
- Empty window: `done` at t+2 with no writes.
- All outputs are driven from registered state; there is no combinational path from inputs to outputs.

## Configuration
- `SEEDER_SPARSE_EN` defined: mode 11 produces the sparse AND-of-two-bits pattern.
- `SEEDER_SPARSE_EN` undefined: mode 11 behaves exactly as mode 10 (random), and the AND logic is not built.

## Test plan
All scenarios use W=4, H=3, `LFSR_WIDTH`=8, `LFSR_TAPS`=8'hB8.
- **Fill:** mode 01, rows 0..2, start at t → writes of 4'b1111 to rows 0, 1, 2 at t+2, t+3, t+4; `done` at t+5.
- **Random:** mode 10, reseed=1, seed 8'h80, rows 0..0 → one write to row 0 at t+6 with data 4'b1000; `lfsr`=8'h08 afterwards; `done` at t+7.
- **Zero seed:** seed 8'h00, reseed=1 → LFSR loads 8'h01, and the first row is 4'b0000.
- **Continuation:** the random run above followed by a run with reseed=0 → the second run's data equals bits 5–8 of one continuous sequence from seed 8'h80.
- **Window bounds:**
  - `row_first`=2, `row_last`=7 → the last row is clamped to 2, giving a single write to row 2;
  - `row_first`=2, `row_last`=1 → no writes, `done` at t+2.
- **Abort and reset:**
  - `abort` during the second row's GEN → no further writes, no `done`, `ready`=1 on the next cycle;
  - `reset` mid-WRITE → strobe low immediately, all outputs at their reset values.
